// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART command sequencer.
// Provides the FSM state encoding, the per-command status codes and
// the default acknowledge byte values.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    RESP,
    DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NAK     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DEF_NAK_BYTE = 8'hEE;

endpackage

// File: rtl/resp_timeout_timer.sv
// Inter-byte response timer.
// Counts enabled cycles since the last clear and flags when the count
// reaches TIMEOUT_CYC-1. The count parks at the terminal value.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   expired  : count == TIMEOUT_CYC-1
module resp_timeout_timer
  import uart_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == TERM);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Host-side command engine for the DSO command link.
// Takes a CMD_BYTES-wide command, sends it MSB byte first through the
// UART transmit handshake, then collects resp_cnt response bytes and
// streams them out, finishing with an OK / NAK / TIMEOUT status.
//   clk, rst     : clock, asynchronous active-high reset
//   cmd_valid    : command request, accepted when cmd_ready is high
//   cmd_data     : command word, top byte sent first
//   resp_cnt     : expected response bytes (0 = no response phase)
//   cmd_ready    : engine idle
//   tx_data/trmt : byte and one-cycle strobe to the UART transmitter
//   tx_done      : transmitter done level, rising edge = byte sent
//   rx_data/rdy  : received byte and its ready level
//   clr_rdy      : one-cycle clear of rdy after a byte is taken
//   resp_valid   : one-cycle strobe qualifying resp_data
//   resp_data    : forwarded response byte
//   done         : one-cycle completion strobe
//   status       : 00 OK, 01 NAK, 10 TIMEOUT, held until next command
//   busy         : high from accept until done
module uart_cmd_sequencer
  import uart_seq_pkg::*;
#(
  parameter int         CMD_BYTES   = 3,
  parameter int         RESP_CNT_W  = 10,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] ACK_BYTE    = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE    = DEF_NAK_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [CMD_BYTES*8-1:0] cmd_data,
  input  logic [RESP_CNT_W-1:0]  resp_cnt,
  output logic                   cmd_ready,
  output logic [7:0]             tx_data,
  output logic                   trmt,
  input  logic                   tx_done,
  input  logic [7:0]             rx_data,
  input  logic                   rdy,
  output logic                   clr_rdy,
  output logic                   resp_valid,
  output logic [7:0]             resp_data,
  output logic                   done,
  output logic [1:0]             status,
  output logic                   busy
);

  localparam int         SH_W     = CMD_BYTES * 8;
  localparam logic [3:0] LAST_IDX = 4'(CMD_BYTES - 1);
  // If ACK and NAK are configured identical the byte is treated as ACK.
  localparam bit         NAK_DETECT = (ACK_BYTE != NAK_BYTE);

  state_t                state, state_n;
  logic [SH_W-1:0]       shift;
  logic [3:0]            byte_idx;
  logic [RESP_CNT_W-1:0] rem;
  logic                  first;
  logic                  tx_done_p1;
  logic                  tx_rise;
  logic                  capture;
  logic                  nak_hit;
  logic                  expired;
  logic                  accept;

  assign tx_data = shift[SH_W-1 -: 8];
  assign tx_rise = tx_done && !tx_done_p1;
  assign accept  = (state == IDLE) && cmd_valid;
  // rdy is still high while the UART acts on clr_rdy, so skip that cycle.
  assign capture = (state == RESP) && rdy && !clr_rdy;
  assign nak_hit = capture && first && NAK_DETECT && (rx_data == NAK_BYTE);

  resp_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state != RESP) || capture),
    .en     (state == RESP),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    trmt      = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = SEND;
      end
      SEND: begin
        busy    = 1'b1;
        trmt    = 1'b1;
        state_n = WAIT_TX;
      end
      WAIT_TX: begin
        busy = 1'b1;
        if (tx_rise) begin
          if (byte_idx == LAST_IDX) state_n = (rem == '0) ? DONE : RESP;
          else                      state_n = SEND;
        end
      end
      RESP: begin
        busy = 1'b1;
        // A byte arriving on the terminal count takes priority.
        if (capture) begin
          if (nak_hit || rem == RESP_CNT_W'(1)) state_n = DONE;
        end else if (expired) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift      <= '0;
      byte_idx   <= '0;
      rem        <= '0;
      first      <= 1'b0;
      status     <= ST_OK;
      resp_data  <= '0;
      resp_valid <= 1'b0;
      clr_rdy    <= 1'b0;
      tx_done_p1 <= 1'b0;
    end else begin
      tx_done_p1 <= tx_done;
      resp_valid <= capture;
      clr_rdy    <= capture;
      if (accept) begin
        shift    <= cmd_data;
        byte_idx <= '0;
        rem      <= resp_cnt;
        first    <= 1'b1;
        status   <= ST_OK;
      end
      if (state == WAIT_TX && tx_rise) begin
        shift    <= shift << 8;
        byte_idx <= byte_idx + 4'd1;
      end
      if (capture) begin
        resp_data <= rx_data;
        rem       <= rem - RESP_CNT_W'(1);
        first     <= 1'b0;
        if (nak_hit) status <= ST_NAK;
      end else if (state == RESP && expired) begin
        status <= ST_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: a 3-byte engine with a short
// response timeout plus a 4-byte fire-and-forget engine, each driven by a
// small UART model.
module tb_uart_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 3-byte engine, 100-cycle timeout
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_data  = '0;
  logic [9:0]  resp_cnt  = '0;
  logic        cmd_ready, trmt, clr_rdy, resp_valid, done, busy;
  logic [7:0]  tx_data, resp_data;
  logic [1:0]  status;
  logic        tx_done = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rdy     = 1'b0;

  uart_cmd_sequencer #(.CMD_BYTES(3), .RESP_CNT_W(10), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .resp_cnt(resp_cnt), .cmd_ready(cmd_ready), .tx_data(tx_data),
    .trmt(trmt), .tx_done(tx_done), .rx_data(rx_data), .rdy(rdy),
    .clr_rdy(clr_rdy), .resp_valid(resp_valid), .resp_data(resp_data),
    .done(done), .status(status), .busy(busy)
  );

  // 4-byte engine, no response phase used
  logic        b_cmd_valid = 1'b0;
  logic [31:0] b_cmd_data  = '0;
  logic [9:0]  b_resp_cnt  = '0;
  logic        b_cmd_ready, b_trmt, b_clr_rdy, b_resp_valid, b_done, b_busy;
  logic [7:0]  b_tx_data, b_resp_data;
  logic [1:0]  b_status;
  logic        b_tx_done = 1'b1;
  logic [7:0]  b_rx_data = '0;
  logic        b_rdy     = 1'b0;

  uart_cmd_sequencer #(.CMD_BYTES(4)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_data(b_cmd_data),
    .resp_cnt(b_resp_cnt), .cmd_ready(b_cmd_ready), .tx_data(b_tx_data),
    .trmt(b_trmt), .tx_done(b_tx_done), .rx_data(b_rx_data), .rdy(b_rdy),
    .clr_rdy(b_clr_rdy), .resp_valid(b_resp_valid), .resp_data(b_resp_data),
    .done(b_done), .status(b_status), .busy(b_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  logic [7:0] tx_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] feed[$];
  logic [1:0] st_q[$];
  logic [7:0] b_tx_q[$];

  int  n_clr = 0, n_done = 0, last_rv = 0, done_cyc = 0;
  int  tx_cnt = 0;
  bit  tx_busy = 1'b0;
  bit  clr_prev = 1'b0;
  bit  rx_flush = 1'b0;

  int  b_n_clr = 0, b_n_rv = 0, b_n_done = 0, b_done_cyc = 0, b_rise_cyc = 0;
  int  b_tx_cnt = 0;
  bit  b_tx_busy = 1'b0;

  // Engine A: scoreboard monitor, then UART transmit and receive models
  always @(negedge clk) begin
    if (!rst) begin
      if (trmt) begin
        chk("tx_uart_idle", 32'(tx_busy), 32'd0);
        if (tx_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        else chk("tx_unexpected", 32'(trmt), 32'd0);
      end
      if (resp_valid) begin
        last_rv = cyc;
        if (resp_q.size() > 0) chk("resp_data", 32'(resp_data), 32'(resp_q.pop_front()));
        else chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end
      if (clr_rdy) n_clr++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (st_q.size() > 0) chk("status", 32'(status), 32'(st_q.pop_front()));
        else chk("done_unexpected", 32'(done), 32'd0);
      end
    end
    // transmitter: done level drops two cycles after trmt, rises four later
    if (trmt && !rst) begin
      tx_busy = 1'b1;
      tx_cnt  = 6;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 4) tx_done = 1'b0;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        tx_busy = 1'b0;
      end
    end
    // receiver: rdy clears one cycle after clr_rdy, next byte a cycle later
    if (rx_flush) begin
      feed.delete();
      rdy      = 1'b0;
      clr_prev = 1'b0;
    end else begin
      if (clr_prev) rdy = 1'b0;
      else if (!rdy && feed.size() > 0) begin
        rx_data = feed.pop_front();
        rdy     = 1'b1;
      end
      clr_prev = clr_rdy;
    end
  end

  // Engine B: monitor and transmitter model
  always @(negedge clk) begin
    if (!rst) begin
      if (b_trmt) begin
        chk("b_tx_uart_idle", 32'(b_tx_busy), 32'd0);
        if (b_tx_q.size() > 0) chk("b_tx_data", 32'(b_tx_data), 32'(b_tx_q.pop_front()));
        else chk("b_tx_unexpected", 32'(b_trmt), 32'd0);
      end
      if (b_clr_rdy) b_n_clr++;
      if (b_resp_valid) b_n_rv++;
      if (b_done) begin
        b_n_done++;
        b_done_cyc = cyc;
      end
    end
    if (b_trmt && !rst) begin
      b_tx_busy = 1'b1;
      b_tx_cnt  = 6;
    end else if (b_tx_cnt > 0) begin
      b_tx_cnt--;
      if (b_tx_cnt == 4) b_tx_done = 1'b0;
      if (b_tx_cnt == 0) begin
        b_tx_done  = 1'b1;
        b_tx_busy  = 1'b0;
        b_rise_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic [23:0] d, input logic [9:0] cnt, input logic [1:0] st);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    tx_q.push_back(d[23:16]);
    tx_q.push_back(d[15:8]);
    tx_q.push_back(d[7:0]);
    st_q.push_back(st);
    cmd_data  = d;
    resp_cnt  = cnt;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accept_to_trmt", 32'(trmt), 32'd1);
  endtask

  task automatic wait_done(input int max, input string tag);
    int start = n_done;
    int t = 0;
    while (n_done == start && t < max) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(n_done - start), 32'd1);
  endtask

  task automatic flush_rx();
    rx_flush = 1'b1;
    @(negedge clk);
    rx_flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t;
    // reset values
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trmt", 32'(trmt), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_resp", {22'd0, resp_valid, clr_rdy, resp_data}, 32'd0);
    chk("rst_b_ready", 32'(b_cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic command, ACK reply already pending before the command
    feed.push_back(8'hA5);
    resp_q.push_back(8'hA5);
    c0 = n_clr;
    issue(24'h020C00, 10'd1, 2'b00);
    @(negedge clk);
    cmd_data  = 24'hFFFFFF;
    cmd_valid = 1'b1;
    chk("ready_while_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("no_clr_during_tx", 32'(n_clr - c0), 32'd0);
    wait_done(200, "done_ack");
    chk("ack_clr_count", 32'(n_clr - c0), 32'd1);
    chk("ack_done_lat", 32'(done_cyc - last_rv), 32'd0);
    @(negedge clk);
    chk("ready_after_done", 32'(cmd_ready), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);

    // 512-byte dump; pattern contains A5 and EE past the first byte
    for (int i = 0; i < 512; i++) begin
      feed.push_back(8'(i));
      resp_q.push_back(8'(i));
    end
    c0 = n_clr;
    issue(24'h010100, 10'd512, 2'b00);
    wait_done(3000, "done_dump");
    chk("dump_clr_count", 32'(n_clr - c0), 32'd512);
    chk("dump_resp_drained", 32'(resp_q.size()), 32'd0);
    chk("dump_done_lat", 32'(done_cyc - last_rv), 32'd0);

    // NAK as first byte; the bytes behind it stay in the UART
    feed.push_back(8'hEE);
    feed.push_back(8'h11);
    feed.push_back(8'h22);
    resp_q.push_back(8'hEE);
    c0 = n_clr;
    issue(24'h031000, 10'd3, 2'b01);
    wait_done(200, "done_nak");
    chk("nak_done_lat", 32'(done_cyc - last_rv), 32'd0);
    repeat (10) @(negedge clk);
    chk("nak_clr_count", 32'(n_clr - c0), 32'd1);
    chk("nak_rdy_left", 32'(rdy), 32'd1);
    chk("nak_rx_left", 32'(rx_data), 32'h11);
    chk("nak_status_held", 32'(status), 32'd1);
    flush_rx();

    // timeout: two bytes expected, one arrives
    feed.push_back(8'h5A);
    resp_q.push_back(8'h5A);
    issue(24'h040000, 10'd2, 2'b10);
    wait_done(400, "done_timeout");
    chk("timeout_gap", 32'(done_cyc - last_rv), 32'd100);
    repeat (5) @(negedge clk);
    chk("timeout_status_held", 32'(status), 32'd2);

    // 4-byte fire-and-forget on engine B
    b_tx_q.push_back(8'hDE);
    b_tx_q.push_back(8'hAD);
    b_tx_q.push_back(8'hBE);
    b_tx_q.push_back(8'hEF);
    b_cmd_data  = 32'hDEADBEEF;
    b_resp_cnt  = 10'd0;
    b_cmd_valid = 1'b1;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    chk("b_busy", 32'(b_busy), 32'd1);
    t = 0;
    while (b_n_done == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("b_done", 32'(b_n_done), 32'd1);
    chk("b_done_lat", 32'(b_done_cyc - b_rise_cyc), 32'd1);
    chk("b_tx_drained", 32'(b_tx_q.size()), 32'd0);
    chk("b_no_clr", 32'(b_n_clr), 32'd0);
    chk("b_no_resp", 32'(b_n_rv), 32'd0);
    chk("b_status", 32'(b_status), 32'd0);
    chk("b_resp_data", 32'(b_resp_data), 32'd0);

    // reset while waiting on the transmitter
    issue(24'h0A0B0C, 10'd1, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_tx_ready", 32'(cmd_ready), 32'd1);
    chk("rst_tx_busy", 32'(busy), 32'd0);
    chk("rst_tx_trmt", 32'(trmt), 32'd0);
    chk("rst_tx_data_mid", 32'(tx_data), 32'd0);
    chk("rst_tx_status", 32'(status), 32'd0);
    tx_q.delete();
    resp_q.delete();
    st_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_tx_ready_after", 32'(cmd_ready), 32'd1);

    // reset while collecting the response
    feed.push_back(8'h77);
    resp_q.push_back(8'h77);
    issue(24'h050607, 10'd3, 2'b00);
    t = 0;
    while (!resp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("resp_seen_before_rst", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_clr", 32'(clr_rdy), 32'd0);
    chk("rst_resp_ready", 32'(cmd_ready), 32'd1);
    tx_q.delete();
    resp_q.delete();
    st_q.delete();
    flush_rx();
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // normal command after the resets
    feed.push_back(8'h3C);
    resp_q.push_back(8'h3C);
    c0 = n_clr;
    issue(24'h020C00, 10'd1, 2'b00);
    wait_done(200, "done_after_rst");
    chk("after_rst_clr", 32'(n_clr - c0), 32'd1);
    chk("after_rst_resp_drained", 32'(resp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
